// File: rtl/otter_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otter_mem_pkg
// Brief    : Shared encodings for the OTTER load/store unit: access sizes,
//            LSU state encoding, default IO region base and an alignment
//            helper.
// Revision : 1.0 - initial release
// ============================================================================
package otter_mem_pkg;

    // Start of the memory-mapped IO region
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

    // Access size encoding shared by the core side and the memory data port
    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    // LSU controller states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_RD_LO    = 3'd2,
        S_RD_HI    = 3'd3,
        S_RD_CAP   = 3'd4,
        S_WR_BYTES = 3'd5,
        S_ERR      = 3'd6
    } lsu_state_e;

    // True when the access fits inside one naturally addressed word
    function automatic logic lsu_is_aligned(input logic [1:0] size,
                                            input logic [1:0] off);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (off != 2'd3);
            SZ_WORD: ok = (off == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/otter_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : otter_lsu_if
// Brief    : Core-side request/response and memory data-port signals of the
//            OTTER load/store unit. The LSU connects through the slave
//            modport; the core/memory environment through the master one.
// Revision : 1.0 - initial release
// ============================================================================
interface otter_lsu_if;

    // Core request side
    logic        LSU_REQ;
    logic        LSU_READY;
    logic [31:0] LSU_ADDR;
    logic [31:0] LSU_WDATA;
    logic        LSU_WE;
    logic [1:0]  LSU_SIZE;
    logic        LSU_SIGN;
    logic        LSU_RVALID;
    logic [31:0] LSU_RDATA;
    logic        LSU_ERR;

    // Memory data port
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic        MEM_WRITE2;
    logic        MEM_READ2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    modport master (
        output LSU_REQ, LSU_ADDR, LSU_WDATA, LSU_WE, LSU_SIZE, LSU_SIGN,
               MEM_DOUT2,
        input  LSU_READY, LSU_RVALID, LSU_RDATA, LSU_ERR,
               MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );

    modport slave (
        input  LSU_REQ, LSU_ADDR, LSU_WDATA, LSU_WE, LSU_SIZE, LSU_SIGN,
               MEM_DOUT2,
        output LSU_READY, LSU_RVALID, LSU_RDATA, LSU_ERR,
               MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );

endinterface
`default_nettype wire

// File: rtl/otter_lsu_extract.sv
`default_nettype none
// ============================================================================
// Module   : otter_lsu_extract
// Brief    : Combinational result formatter for split loads: shifts the
//            {hi,lo} word pair right by the byte offset, truncates to the
//            access size and zero- or sign-extends to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module otter_lsu_extract
    import otter_mem_pkg::*;
(
    input  logic [63:0] data_i,     // {hi_word, lo_word}
    input  logic [1:0]  offset_i,   // byte offset of the request address
    input  logic [1:0]  size_i,
    input  logic        zext_i,     // 1 = zero-extend, 0 = sign-extend
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    assign shifted = 32'(data_i >> {offset_i, 3'b000});

    // Truncate to the access size and extend to a full word
    always_comb begin
        result_o = shifted;
        case (size_i)
            SZ_BYTE: result_o = {{24{~zext_i & shifted[7]}},  shifted[7:0]};
            SZ_HALF: result_o = {{16{~zext_i & shifted[15]}}, shifted[15:0]};
            default: result_o = shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/otter_lsu.sv
`default_nettype none
// ============================================================================
// Module   : otter_lsu
// Brief    : OTTER load/store unit. Accepts one request at a time from the
//            core, issues registered strobes on the memory data port, splits
//            misaligned loads into two word reads and misaligned stores into
//            byte writes, and rejects illegal or IO-crossing accesses.
// Revision : 1.0 - initial release
// ============================================================================
module otter_lsu
    import otter_mem_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        MEM_CLK,
    input  logic        MEM_RST_N,
    otter_lsu_if.slave  bus
);

    localparam logic [2:0] ST_IDLE     = S_IDLE;
    localparam logic [2:0] ST_RD_WAIT  = S_RD_WAIT;
    localparam logic [2:0] ST_RD_LO    = S_RD_LO;
    localparam logic [2:0] ST_RD_HI    = S_RD_HI;
    localparam logic [2:0] ST_RD_CAP   = S_RD_CAP;
    localparam logic [2:0] ST_WR_BYTES = S_WR_BYTES;
    localparam logic [2:0] ST_ERR      = S_ERR;

    // Controller state
    logic [2:0]  state_q,  state_d;
    logic        phase_q,  phase_d;   // RD_WAIT: 0 = strobe just issued, 1 = data valid
    logic [1:0]  k_q,      k_d;       // index of the byte being written
    logic [1:0]  last_q,   last_d;    // index of the final byte write
    logic        split_q,  split_d;   // load was split into two word reads

    // Request copies taken at acceptance
    logic [31:0] req_addr_q,  req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [1:0]  req_size_q,  req_size_d;
    logic        req_sign_q,  req_sign_d;

    // Load data
    logic [31:0] lo_q,    lo_d;
    logic [31:0] rdata_q, rdata_d;

    // Registered memory port
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_din_q,   mem_din_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q,  mem_read_d;
    logic [1:0]  mem_size_q,  mem_size_d;
    logic        mem_sign_q,  mem_sign_d;

    // Decode of the live request (only meaningful in IDLE)
    logic [1:0]  in_off;
    logic        in_aligned;
    logic [31:0] in_base;
    logic [31:0] in_hi_base;
    logic        in_io;
    logic        in_err;
    logic [1:0]  k_next;
    logic [31:0] split_result;

    assign in_off     = bus.LSU_ADDR[1:0];
    assign in_aligned = lsu_is_aligned(bus.LSU_SIZE, in_off);
    assign in_base    = {bus.LSU_ADDR[31:2], 2'b00};
    assign in_hi_base = in_base + 32'd4;
    assign in_io      = (bus.LSU_ADDR >= IO_BASE);
    // A split access must stay entirely below the IO region
    assign in_err     = (bus.LSU_SIZE == SZ_ILLEGAL)
                      || (in_io && (in_off != 2'd0))
                      || (!in_aligned && (in_hi_base >= IO_BASE));
    assign k_next     = k_q + 2'd1;

    otter_lsu_extract u_extract (
        .data_i   ({bus.MEM_DOUT2, lo_q}),
        .offset_i (req_addr_q[1:0]),
        .size_i   (req_size_q),
        .zext_i   (req_sign_q),
        .result_o (split_result)
    );

    // Next-state and next memory-port values
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        k_d         = k_q;
        last_d      = last_q;
        split_d     = split_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_size_d  = req_size_q;
        req_sign_d  = req_sign_q;
        lo_d        = lo_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_size_d  = mem_size_q;
        mem_sign_d  = mem_sign_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.LSU_REQ) begin
                    req_addr_d  = bus.LSU_ADDR;
                    req_wdata_d = bus.LSU_WDATA;
                    req_size_d  = bus.LSU_SIZE;
                    req_sign_d  = bus.LSU_SIGN;
                    split_d     = !in_aligned;
                    phase_d     = 1'b0;
                    k_d         = 2'd0;
                    last_d      = 2'd0;
                    if (in_err) begin
                        state_d = ST_ERR;
                    end else if (bus.LSU_WE) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = bus.LSU_ADDR;
                        state_d     = ST_WR_BYTES;
                        if (in_aligned) begin
                            mem_din_d  = bus.LSU_WDATA;
                            mem_size_d = bus.LSU_SIZE;
                            mem_sign_d = bus.LSU_SIGN;
                        end else begin
                            mem_din_d  = {24'd0, bus.LSU_WDATA[7:0]};
                            mem_size_d = SZ_BYTE;
                            mem_sign_d = 1'b0;
                            last_d     = (bus.LSU_SIZE == SZ_HALF) ? 2'd1 : 2'd3;
                        end
                    end else begin
                        mem_read_d = 1'b1;
                        if (in_aligned) begin
                            mem_addr_d = bus.LSU_ADDR;
                            mem_size_d = bus.LSU_SIZE;
                            mem_sign_d = bus.LSU_SIGN;
                            state_d    = ST_RD_WAIT;
                        end else begin
                            mem_addr_d = in_base;
                            mem_size_d = SZ_WORD;
                            mem_sign_d = 1'b0;
                            state_d    = ST_RD_LO;
                        end
                    end
                end
            end
            ST_RD_LO: begin
                mem_read_d = 1'b1;
                mem_addr_d = {req_addr_q[31:2], 2'b00} + 32'd4;
                state_d    = ST_RD_HI;
            end
            ST_RD_HI: begin
                lo_d    = bus.MEM_DOUT2;
                phase_d = 1'b1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    rdata_d = split_q ? split_result : bus.MEM_DOUT2;
                    state_d = ST_RD_CAP;
                end
            end
            ST_RD_CAP: begin
                state_d = ST_IDLE;
            end
            ST_WR_BYTES: begin
                if (k_q == last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_write_d = 1'b1;
                    k_d         = k_next;
                    mem_addr_d  = req_addr_q + {30'd0, k_next};
                    mem_din_d   = {24'd0, req_wdata_q[{k_next, 3'b000} +: 8]};
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            k_q         <= 2'd0;
            last_q      <= 2'd0;
            split_q     <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_size_q  <= 2'd0;
            req_sign_q  <= 1'b0;
            lo_q        <= 32'd0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_din_q   <= 32'd0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_size_q  <= 2'd0;
            mem_sign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            k_q         <= k_d;
            last_q      <= last_d;
            split_q     <= split_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_size_q  <= req_size_d;
            req_sign_q  <= req_sign_d;
            lo_q        <= lo_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_size_q  <= mem_size_d;
            mem_sign_q  <= mem_sign_d;
        end
    end

    assign bus.LSU_READY  = (state_q == ST_IDLE);
    assign bus.LSU_RVALID = (state_q == ST_RD_CAP);
    assign bus.LSU_ERR    = (state_q == ST_ERR);
    assign bus.LSU_RDATA  = rdata_q;
    assign bus.MEM_ADDR2  = mem_addr_q;
    assign bus.MEM_DIN2   = mem_din_q;
    assign bus.MEM_WRITE2 = mem_write_q;
    assign bus.MEM_READ2  = mem_read_q;
    assign bus.MEM_SIZE   = mem_size_q;
    assign bus.MEM_SIGN   = mem_sign_q;

endmodule
`default_nettype wire

// File: tb/tb_otter_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_lsu
// Brief    : Directed self-checking bench for otter_lsu with a word memory
//            model answering reads one cycle after MEM_READ2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_lsu;
    import otter_mem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem [bit [29:0]];

    otter_lsu_if bus ();

    otter_lsu #(.IO_BASE(32'h1100_0000)) dut (
        .MEM_CLK   (clk),
        .MEM_RST_N (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Word memory: read data appears in the cycle after the strobe
    always @(posedge clk) begin
        if (bus.MEM_READ2 === 1'b1)
            bus.MEM_DOUT2 <= mem.exists(bus.MEM_ADDR2[31:2]) ? mem[bus.MEM_ADDR2[31:2]] : 32'h0;
    end

    // Read and write strobes are mutually exclusive
    always @(negedge clk) begin
        assert (!(bus.MEM_READ2 === 1'b1 && bus.MEM_WRITE2 === 1'b1)) else begin
            bad++;
            $error("FAIL rw_exclusive: observed read=1 write=1 expected not both");
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.LSU_REQ   = 1'b1;
        bus.LSU_WE    = we;
        bus.LSU_SIZE  = size;
        bus.LSU_SIGN  = sign;
        bus.LSU_ADDR  = addr;
        bus.LSU_WDATA = wdata;
    endtask

    // Drop the request and scramble the other inputs; the LSU must ignore them
    task automatic drop();
        bus.LSU_REQ   = 1'b0;
        bus.LSU_ADDR  = 32'h0000_0FF0;
        bus.LSU_WDATA = 32'hFFFF_FFFF;
        bus.LSU_SIZE  = 2'd3;
        bus.LSU_WE    = 1'b0;
    endtask

    task automatic split_load(input string tag, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, size, sign, addr, 32'h0);
        step(); drop();
        step(); step();
        chk({tag, "_rvalid_t3"}, bus.LSU_RVALID, 1'b0);
        step();
        chk({tag, "_rvalid"}, bus.LSU_RVALID, 1'b1);
        chk({tag, "_rdata"}, bus.LSU_RDATA, exp);
        step();
        chk({tag, "_ready"}, bus.LSU_READY, 1'b1);
    endtask

    task automatic err_req(input string tag, input logic [1:0] size, input logic [31:0] addr);
        issue(1'b0, size, 1'b0, addr, 32'h0);
        step(); drop();
        chk({tag, "_err"}, bus.LSU_ERR, 1'b1);
        chk({tag, "_rd"}, bus.MEM_READ2, 1'b0);
        chk({tag, "_wr"}, bus.MEM_WRITE2, 1'b0);
        step();
        chk({tag, "_err_clr"}, bus.LSU_ERR, 1'b0);
        chk({tag, "_ready"}, bus.LSU_READY, 1'b1);
    endtask

    initial begin
        logic [7:0] sw_bytes [4];
        sw_bytes = '{8'h44, 8'h33, 8'h22, 8'h11};
        drop();

        // Reset state
        step(); step();
        chk("rst_ready", bus.LSU_READY, 1'b1);
        chk("rst_rvalid", bus.LSU_RVALID, 1'b0);
        chk("rst_err", bus.LSU_ERR, 1'b0);
        chk("rst_rdata", bus.LSU_RDATA, 32'h0);
        chk("rst_rd", bus.MEM_READ2, 1'b0);
        chk("rst_wr", bus.MEM_WRITE2, 1'b0);
        chk("rst_addr", bus.MEM_ADDR2, 32'h0);
        rst_n = 1'b1;
        step();

        // Aligned lw at 0x100
        mem[30'h40] = 32'hDEAD_BEEF;
        issue(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
        chk("lw_ready_t0", bus.LSU_READY, 1'b1);
        step(); drop();
        chk("lw_rd_t1", bus.MEM_READ2, 1'b1);
        chk("lw_addr_t1", bus.MEM_ADDR2, 32'h100);
        chk("lw_size_t1", bus.MEM_SIZE, SZ_WORD);
        chk("lw_busy_t1", bus.LSU_READY, 1'b0);
        step();
        chk("lw_rd_t2", bus.MEM_READ2, 1'b0);
        chk("lw_addr_t2", bus.MEM_ADDR2, 32'h100);
        step();
        chk("lw_rvalid_t3", bus.LSU_RVALID, 1'b1);
        chk("lw_rdata_t3", bus.LSU_RDATA, 32'hDEAD_BEEF);
        step();
        chk("lw_ready_t4", bus.LSU_READY, 1'b1);
        chk("lw_rvalid_t4", bus.LSU_RVALID, 1'b0);

        // Misaligned lh at 0x103, sign-extended
        mem[30'h40] = 32'hAB00_0000;
        mem[30'h41] = 32'h0000_00CD;
        issue(1'b0, SZ_HALF, 1'b0, 32'h103, 32'h0);
        step(); drop();
        chk("lh_rd_t1", bus.MEM_READ2, 1'b1);
        chk("lh_addr_t1", bus.MEM_ADDR2, 32'h100);
        chk("lh_size_t1", bus.MEM_SIZE, SZ_WORD);
        chk("lh_sign_t1", bus.MEM_SIGN, 1'b0);
        step();
        chk("lh_rd_t2", bus.MEM_READ2, 1'b1);
        chk("lh_addr_t2", bus.MEM_ADDR2, 32'h104);
        step();
        chk("lh_rd_t3", bus.MEM_READ2, 1'b0);
        chk("lh_rvalid_t3", bus.LSU_RVALID, 1'b0);
        step();
        chk("lh_rvalid_t4", bus.LSU_RVALID, 1'b1);
        chk("lh_rdata_t4", bus.LSU_RDATA, 32'hFFFF_CDAB);
        step();
        chk("lh_ready_t5", bus.LSU_READY, 1'b1);

        // More split loads: word at offset 1, unsigned half at offset 3
        mem[30'h80] = 32'h3322_1100;
        mem[30'h81] = 32'h7766_F5C4;
        split_load("lw201", SZ_WORD, 1'b0, 32'h201, 32'hC433_2211);
        split_load("lhu203", SZ_HALF, 1'b1, 32'h203, 32'h0000_C433);
        split_load("lh203", SZ_HALF, 1'b0, 32'h203, 32'hFFFF_C433);

        // Misaligned sw at 0x101 becomes four byte writes
        issue(1'b1, SZ_WORD, 1'b0, 32'h101, 32'h1122_3344);
        step(); drop();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sw_wr_%0d", k), bus.MEM_WRITE2, 1'b1);
            chk($sformatf("sw_addr_%0d", k), bus.MEM_ADDR2, 32'h101 + k);
            chk($sformatf("sw_size_%0d", k), bus.MEM_SIZE, SZ_BYTE);
            chk($sformatf("sw_byte_%0d", k), bus.MEM_DIN2[7:0], sw_bytes[k]);
            chk($sformatf("sw_busy_%0d", k), bus.LSU_READY, 1'b0);
            step();
        end
        chk("sw_wr_end", bus.MEM_WRITE2, 1'b0);
        chk("sw_ready_t5", bus.LSU_READY, 1'b1);

        // Aligned sw at 0x300
        issue(1'b1, SZ_WORD, 1'b0, 32'h300, 32'hCAFE_F00D);
        step(); drop();
        chk("swa_wr_t1", bus.MEM_WRITE2, 1'b1);
        chk("swa_addr_t1", bus.MEM_ADDR2, 32'h300);
        chk("swa_din_t1", bus.MEM_DIN2, 32'hCAFE_F00D);
        chk("swa_size_t1", bus.MEM_SIZE, SZ_WORD);
        step();
        chk("swa_wr_t2", bus.MEM_WRITE2, 1'b0);
        chk("swa_ready_t2", bus.LSU_READY, 1'b1);

        // Rejected requests
        err_req("e_size3", 2'd3, 32'h200);
        err_req("e_io_mis", SZ_WORD, 32'h1100_0002);
        err_req("e_io_cross", SZ_WORD, 32'h10FF_FFFE);

        // Aligned word exactly at IO_BASE is legal
        mem[30'h0440_0000] = 32'h1234_5678;
        issue(1'b0, SZ_WORD, 1'b0, 32'h1100_0000, 32'h0);
        step(); drop();
        chk("io_rd_t1", bus.MEM_READ2, 1'b1);
        chk("io_err_t1", bus.LSU_ERR, 1'b0);
        chk("io_addr_t1", bus.MEM_ADDR2, 32'h1100_0000);
        step(); step();
        chk("io_rvalid_t3", bus.LSU_RVALID, 1'b1);
        chk("io_rdata_t3", bus.LSU_RDATA, 32'h1234_5678);
        step();

        // Reset in the middle of a load
        issue(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
        step(); drop();
        step();
        rst_n = 1'b0;
        #1;
        chk("mr_ready", bus.LSU_READY, 1'b1);
        chk("mr_rvalid", bus.LSU_RVALID, 1'b0);
        chk("mr_rdata", bus.LSU_RDATA, 32'h0);
        chk("mr_rd", bus.MEM_READ2, 1'b0);
        chk("mr_wr", bus.MEM_WRITE2, 1'b0);
        chk("mr_addr", bus.MEM_ADDR2, 32'h0);
        chk("mr_din", bus.MEM_DIN2, 32'h0);
        chk("mr_size", bus.MEM_SIZE, 2'd0);
        step();
        chk("mr_rvalid_hold", bus.LSU_RVALID, 1'b0);
        rst_n = 1'b1;
        step();
        chk("mr_rvalid_post", bus.LSU_RVALID, 1'b0);
        chk("mr_rd_post", bus.MEM_READ2, 1'b0);
        chk("mr_ready_post", bus.LSU_READY, 1'b1);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h7, 32'h0000_005A);
        step(); drop();
        chk("sb_wr", bus.MEM_WRITE2, 1'b1);
        chk("sb_size", bus.MEM_SIZE, SZ_BYTE);
        chk("sb_addr", bus.MEM_ADDR2, 32'h7);
        chk("sb_din", bus.MEM_DIN2[7:0], 8'h5A);
        step();
        chk("sb_ready", bus.LSU_READY, 1'b1);

        // Request held high: one accept per READY cycle
        issue(1'b1, SZ_WORD, 1'b0, 32'h400, 32'h1);
        for (int c = 1; c <= 6; c++) begin
            step();
            chk($sformatf("hold_wr_%0d", c), bus.MEM_WRITE2, (c % 2 == 1) ? 1'b1 : 1'b0);
            chk($sformatf("hold_ready_%0d", c), bus.LSU_READY, (c % 2 == 0) ? 1'b1 : 1'b0);
        end
        drop();
        step();
        chk("hold_wr_end", bus.MEM_WRITE2, 1'b0);
        chk("hold_ready_end", bus.LSU_READY, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/otter_lsu.md
OTTER_LSU -- requirements
Module: otter_lsu

Interface
REQ-001 Parameter: IO_BASE, default 32'h11000000, start of the memory-mapped IO region; addresses at or above it are IO.
REQ-002 MEM_CLK  in  1  the only clock; all state updates on the rising edge.
REQ-003 MEM_RST_N  in  1  asynchronous, active-low reset.
REQ-004 LSU_REQ  in  1  request valid from the core; sampled only while LSU_READY=1.
REQ-005 LSU_READY  out  1  LSU idle and able to accept a request.
REQ-006 LSU_ADDR  in  32  byte address.
REQ-007 LSU_WDATA  in  32  store data, right-aligned.
REQ-008 LSU_WE  in  1  1=store, 0=load.
REQ-009 LSU_SIZE  in  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-010 LSU_SIGN  in  1  1=zero-extend (unsigned load), 0=sign-extend.
REQ-011 LSU_RVALID  out  1  one-cycle pulse; LSU_RDATA holds the load result.
REQ-012 LSU_RDATA  out  32  load result, held until the next load completes.
REQ-013 LSU_ERR  out  1  one-cycle pulse; request rejected with no memory access.
REQ-014 MEM_ADDR2, MEM_DIN2  out  32 each  data-port address and write data.
REQ-015 MEM_WRITE2, MEM_READ2  out  1 each  data-port write and read strobes.
REQ-016 MEM_SIZE  out  2; MEM_SIGN  out  1  data-port access size and sign, same encoding as LSU_SIZE and LSU_SIGN.
REQ-017 MEM_DOUT2  in  32  data-port read data, valid in the cycle after MEM_READ2 while address, size and sign are held.

Function
REQ-018 All MEM_* outputs SHALL be registered; LSU_READY SHALL be 1 exactly in state IDLE.
REQ-019 A request is accepted in cycle T when LSU_REQ=1 and LSU_READY=1; the first memory strobe SHALL appear in T+1.
REQ-020 An access is aligned when it is a byte access, a half with ADDR[1:0]!=3, or a word with ADDR[1:0]=0; otherwise it is misaligned.
REQ-021 Error cases: SIZE=3; an IO address with ADDR[1:0]!=0; a split access whose second word reaches IO_BASE or above. Each SHALL pulse LSU_ERR in T+1 with no strobe, then return to IDLE.
REQ-022 Aligned load: MEM_READ2=1 in T+1 with the request's address, size and sign; these are held through T+2; MEM_DOUT2 is captured at the end of T+2; LSU_RVALID=1 in T+3; LSU_READY=1 in T+4.
REQ-023 Aligned store: MEM_WRITE2=1 for T+1 only, with the request's address, data and size; LSU_READY=1 in T+2.
REQ-024 Misaligned load (states RD_LO, RD_HI, RD_CAP), in sequence:
  - T+1: word read (MEM_SIZE=2, MEM_SIGN=0) at ADDR&~3.
  - T+2: word read at (ADDR&~3)+4, computed mod 2^32 (wraps); the low word is captured at the end of T+2.
  - End of T+3: the high word is captured.
  - Result: {hi,lo} >> (8*ADDR[1:0]), truncated to the request size, extended per LSU_SIGN.
  - LSU_RVALID=1 in T+4.
REQ-025 Misaligned store (state WR_BYTES): N=2 (half) or N=4 (word) byte writes, one per cycle in T+1..T+N, with MEM_SIZE=0, MEM_ADDR2=ADDR+k mod 2^32 and MEM_DIN2[7:0]=WDATA byte k, for k=0..N-1. LSU_READY=1 in T+N+1.
REQ-026 IO accesses SHALL never be split; MEM_READ2 and MEM_WRITE2 SHALL never both be 1 in the same cycle.
REQ-027 LSU_REQ and LSU inputs while LSU_READY=0 SHALL be ignored; the LSU SHALL use only copies registered at acceptance.
REQ-028 State set: IDLE, RD_WAIT, RD_LO, RD_HI, RD_CAP, WR_BYTES, ERR; every terminal state returns to IDLE.

Reset
REQ-029 While MEM_RST_N=0: state=IDLE, and all MEM_* outputs, LSU_RVALID, LSU_ERR and LSU_RDATA SHALL be 0; LSU_READY=1.
REQ-030 Reset asserted mid-operation SHALL drop the operation immediately with no further strobe and no RVALID; the first accept after release SHALL be served normally.

Structure
REQ-031 Package otter_mem_pkg SHALL hold the size encoding (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), the state enum and the IO_BASE default.
REQ-032 One combinational sub-module, otter_lsu_extract, SHALL implement the shift/truncate/extend of REQ-024; no other sub-modules.

Verification
REQ-033 Aligned lw at 0x100, memory word 0xDEADBEEF -> MEM_READ2 in T+1; LSU_RDATA=0xDEADBEEF with LSU_RVALID in T+3.
REQ-034 lh at 0x103, SIGN=0, words [0x100]=0xAB000000, [0x104]=0x000000CD -> two reads (0x100 then 0x104); LSU_RDATA=0xFFFFCDAB in T+4.
REQ-035 sw 0x11223344 at 0x101 -> byte writes to 0x101..0x104 of 0x44, 0x33, 0x22, 0x11 in T+1..T+4; LSU_READY in T+5.
REQ-036 Error requests, each -> LSU_ERR pulse in T+1 and no strobe:
  - SIZE=3 at 0x200.
  - lw at 0x11000002.
  - lw at 0x10FFFFFE.
REQ-037 Load accepted, MEM_RST_N=0 in T+2 -> all outputs 0 and no RVALID; after release, sb 0x5A at 0x7 -> MEM_WRITE2, MEM_SIZE=0, MEM_ADDR2=0x7.
REQ-038 Requests with LSU_REQ held high continuously -> each accepted only in an LSU_READY cycle; no duplicate strobes.
